// File: rtl/decode_buf_pkg.sv
// Shared widths, op codes, tp encodings and the queue entry record for the decode buffer.
package decode_buf_pkg;

    localparam int DAT_W     = 32;
    localparam int RAM_ADR_W = 32;
    localparam int REG_BIT   = 5;
    localparam int OP_W      = 6;

    typedef enum logic [1:0] {
        TP_BR  = 2'd0,
        TP_LD  = 2'd1,
        TP_ST  = 2'd2,
        TP_ALU = 2'd3
    } tp_e;

    // OP_ILL stays at 0 so an illegal entry always carries op=0.
    typedef enum logic [OP_W-1:0] {
        OP_ILL, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic                 ic;
        tp_e                  tp;
        op_e                  op;
        logic [REG_BIT-1:0]   rd;
        logic [REG_BIT-1:0]   rs1;
        logic [REG_BIT-1:0]   rs2;
        logic [DAT_W-1:0]     imm;
        logic [RAM_ADR_W-1:0] pc;
        logic                 pbr;
        logic                 ill;
    } entry_t;

endpackage

// File: rtl/rv_dec_core.sv
// Purely combinational RV32I / RV32C instruction decoder feeding the decode queue.
module rv_dec_core
    import decode_buf_pkg::*;
#(
    parameter int C_EN = 1
) (
    input  logic [DAT_W-1:0]   ins,
    input  logic               ic,
    output tp_e                tp,
    output op_e                op,
    output logic [REG_BIT-1:0] rd,
    output logic [REG_BIT-1:0] rs1,
    output logic [REG_BIT-1:0] rs2,
    output logic [DAT_W-1:0]   imm,
    output logic               ill
);

    logic [2:0]         f3;
    logic [REG_BIT-1:0] i_rd, i_rs1, i_rs2, c_rd, c_rs2, c_rdp, c_rs1p;
    logic [DAT_W-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [DAT_W-1:0]   c_imm6, c_sh, c_j, c_b, c_lw, c_lwsp, c_swsp, c_a16, c_a4, c_lui;

    assign f3     = ins[14:12];
    assign i_rd   = ins[11:7];
    assign i_rs1  = ins[19:15];
    assign i_rs2  = ins[24:20];
    assign c_rd   = ins[11:7];
    assign c_rs2  = ins[6:2];
    assign c_rdp  = {2'b01, ins[4:2]};
    assign c_rs1p = {2'b01, ins[9:7]};

    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_sh = {27'b0, ins[24:20]};

    // Compressed immediates are scattered across the halfword; each is reassembled into byte offsets.
    assign c_imm6 = {{26{ins[12]}}, ins[12], ins[6:2]};
    assign c_sh   = {26'b0, ins[12], ins[6:2]};
    assign c_j    = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0};
    assign c_b    = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
    assign c_lw   = {25'b0, ins[5], ins[12:10], ins[6], 2'b0};
    assign c_lwsp = {24'b0, ins[3:2], ins[12], ins[6:4], 2'b0};
    assign c_swsp = {24'b0, ins[8:7], ins[12:9], 2'b0};
    assign c_a16  = {{22{ins[12]}}, ins[12], ins[4:3], ins[5], ins[2], ins[6], 4'b0};
    assign c_a4   = {22'b0, ins[10:7], ins[12:11], ins[5], ins[6], 2'b0};
    assign c_lui  = {{14{ins[12]}}, ins[12], ins[6:2], 12'b0};

    // NOTE: every output gets a default first so no path through the case tree infers a latch.
    always_comb begin
        tp = TP_ALU; op = OP_ILL; rd = '0; rs1 = '0; rs2 = '0; imm = '0; ill = 1'b0;
        if (!ic) begin
            case (ins[6:0])
                OPC_LUI:   begin op = OP_LUI;   rd = i_rd; imm = imm_u; end
                OPC_AUIPC: begin op = OP_AUIPC; rd = i_rd; imm = imm_u; end
                OPC_JAL:   begin op = OP_JAL;   rd = i_rd; imm = imm_j; end
                OPC_JALR:  begin op = OP_JALR; tp = TP_BR; rd = i_rd; rs1 = i_rs1; imm = imm_i; ill = (f3 != 3'b000); end
                OPC_BRANCH: begin
                    tp = TP_BR; rs1 = i_rs1; rs2 = i_rs2; imm = imm_b;
                    case (f3)
                        3'b000: op = OP_BEQ;  3'b001: op = OP_BNE;
                        3'b100: op = OP_BLT;  3'b101: op = OP_BGE;
                        3'b110: op = OP_BLTU; 3'b111: op = OP_BGEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    tp = TP_LD; rd = i_rd; rs1 = i_rs1; imm = imm_i;
                    case (f3)
                        3'b000: op = OP_LB;  3'b001: op = OP_LH; 3'b010: op = OP_LW;
                        3'b100: op = OP_LBU; 3'b101: op = OP_LHU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    tp = TP_ST; rs1 = i_rs1; rs2 = i_rs2; imm = imm_s;
                    case (f3)
                        3'b000: op = OP_SB; 3'b001: op = OP_SH; 3'b010: op = OP_SW;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_OPIMM: begin
                    rd = i_rd; rs1 = i_rs1; imm = imm_i;
                    case (f3)
                        3'b000: op = OP_ADDI;  3'b010: op = OP_SLTI; 3'b011: op = OP_SLTIU;
                        3'b100: op = OP_XORI;  3'b110: op = OP_ORI;  3'b111: op = OP_ANDI;
                        3'b001: begin op = OP_SLLI; imm = imm_sh; end
                        default: begin op = ins[30] ? OP_SRAI : OP_SRLI; imm = imm_sh; end
                    endcase
                end
                OPC_OP: begin
                    rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
                    case (f3)
                        3'b000: op = ins[30] ? OP_SUB : OP_ADD;
                        3'b001: op = OP_SLL;  3'b010: op = OP_SLT; 3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;  3'b101: op = ins[30] ? OP_SRA : OP_SRL;
                        3'b110: op = OP_OR;   default: op = OP_AND;
                    endcase
                end
                default: ill = 1'b1;
            endcase
        end else if (C_EN == 0) begin
            ill = 1'b1;
        end else begin
            case ({ins[1:0], ins[15:13]})
                5'b00_000: begin op = OP_ADDI; rd = c_rdp; rs1 = REG_BIT'(2); imm = c_a4; ill = (ins[12:5] == 8'd0); end
                5'b00_010: begin op = OP_LW; tp = TP_LD; rd = c_rdp; rs1 = c_rs1p; imm = c_lw; end
                5'b00_110: begin op = OP_SW; tp = TP_ST; rs1 = c_rs1p; rs2 = c_rdp; imm = c_lw; end
                5'b01_000: begin op = OP_ADDI; rd = c_rd; rs1 = c_rd; imm = c_imm6; end
                5'b01_001: begin op = OP_JAL; rd = REG_BIT'(1); imm = c_j; end
                5'b01_010: begin op = OP_ADDI; rd = c_rd; imm = c_imm6; end
                5'b01_011: begin
                    if (c_rd == REG_BIT'(2)) begin op = OP_ADDI; rd = c_rd; rs1 = c_rd; imm = c_a16; end
                    else begin op = OP_LUI; rd = c_rd; imm = c_lui; end
                end
                5'b01_100: begin
                    rd = c_rs1p; rs1 = c_rs1p;
                    case (ins[11:10])
                        2'b00: begin op = OP_SRLI; imm = c_sh; end
                        2'b01: begin op = OP_SRAI; imm = c_sh; end
                        2'b10: begin op = OP_ANDI; imm = c_imm6; end
                        default: begin
                            rs2 = c_rdp;
                            case ({ins[12], ins[6:5]})
                                3'b000: op = OP_SUB; 3'b001: op = OP_XOR;
                                3'b010: op = OP_OR;  3'b011: op = OP_AND;
                                default: ill = 1'b1;
                            endcase
                        end
                    endcase
                end
                5'b01_101: begin op = OP_JAL; imm = c_j; end
                5'b01_110: begin op = OP_BEQ; tp = TP_BR; rs1 = c_rs1p; imm = c_b; end
                5'b01_111: begin op = OP_BNE; tp = TP_BR; rs1 = c_rs1p; imm = c_b; end
                5'b10_000: begin op = OP_SLLI; rd = c_rd; rs1 = c_rd; imm = c_sh; end
                5'b10_010: begin op = OP_LW; tp = TP_LD; rd = c_rd; rs1 = REG_BIT'(2); imm = c_lwsp; end
                5'b10_100: begin
                    if (c_rs2 != '0) begin
                        op = OP_ADD; rd = c_rd; rs1 = ins[12] ? c_rd : '0; rs2 = c_rs2;
                    end else if (c_rd == '0) begin
                        ill = 1'b1;
                    end else begin
                        op = OP_JALR; tp = TP_BR; rd = ins[12] ? REG_BIT'(1) : '0; rs1 = c_rd;
                    end
                end
                5'b10_110: begin op = OP_SW; tp = TP_ST; rs1 = REG_BIT'(2); rs2 = c_rs2; imm = c_swsp; end
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            tp = TP_ALU; op = OP_ILL; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        end
    end

endmodule

// File: rtl/decode_buf.sv
// Decoded-instruction queue between fetch and issue: decodes on push, holds DEPTH records in order.
module decode_buf
    import decode_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int C_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    if_valid_i,
    output logic                    if_ready_o,
    input  logic                    if_ic_i,
    input  logic [DAT_W-1:0]        if_ins_i,
    input  logic [RAM_ADR_W-1:0]    if_pc_i,
    input  logic                    if_pbr_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_ic_o,
    output logic [1:0]              out_tp_o,
    output logic [OP_W-1:0]         out_op_o,
    output logic [REG_BIT-1:0]      out_rd_o,
    output logic [REG_BIT-1:0]      out_rs1_o,
    output logic [REG_BIT-1:0]      out_rs2_o,
    output logic [DAT_W-1:0]        out_imm_o,
    output logic [RAM_ADR_W-1:0]    out_pc_o,
    output logic                    out_pbr_o,
    output logic                    out_ill_o,
    output logic [$clog2(DEPTH):0]  cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    entry_t        mem_q [DEPTH];
    entry_t        wr_entry, head;
    logic          push, pop;

    tp_e                dec_tp;
    op_e                dec_op;
    logic [REG_BIT-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [DAT_W-1:0]   dec_imm;
    logic               dec_ill;

    rv_dec_core #(.C_EN(C_EN)) u_dec (
        .ins (if_ins_i), .ic  (if_ic_i),
        .tp  (dec_tp),   .op  (dec_op),
        .rd  (dec_rd),   .rs1 (dec_rs1), .rs2 (dec_rs2),
        .imm (dec_imm),  .ill (dec_ill)
    );

    // Ready looks only at the registered count, so a pop never re-opens a full queue in the same cycle.
    assign if_ready_o  = en && (cnt_q < CNT_FULL);
    assign out_valid_o = (cnt_q != '0);
    assign push        = en && !clr && if_valid_i && if_ready_o;
    assign pop         = en && !clr && out_valid_o && out_ready_i;

    always_comb begin
        wr_entry = '{ic: if_ic_i, tp: dec_tp, op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                     imm: dec_imm, pc: if_pc_i, pbr: if_pbr_i, ill: dec_ill};
        head     = out_valid_o ? mem_q[rd_ptr_q] : '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: entry storage is not reset; cnt_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign out_ic_o  = head.ic;
    assign out_tp_o  = head.tp;
    assign out_op_o  = head.op;
    assign out_rd_o  = head.rd;
    assign out_rs1_o = head.rs1;
    assign out_rs2_o = head.rs2;
    assign out_imm_o = head.imm;
    assign out_pc_o  = head.pc;
    assign out_pbr_o = head.pbr;
    assign out_ill_o = head.ill;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_decode_buf.sv
// Directed bench for decode_buf: decode results, handshake, full/flush/enable/reset behaviour.
module tb_decode_buf;
    import decode_buf_pkg::*;

    logic clk = 1'b0;
    logic rst, en, clr, if_valid_i, if_ic_i, if_pbr_i, out_ready_i;
    logic [31:0] if_ins_i, if_pc_i;

    logic if_ready_o, out_valid_o, out_ic_o, out_pbr_o, out_ill_o;
    logic [1:0] out_tp_o;
    logic [5:0] out_op_o;
    logic [4:0] out_rd_o, out_rs1_o, out_rs2_o;
    logic [31:0] out_imm_o, out_pc_o;
    logic [2:0] cnt_o;

    logic n_if_ready_o, n_out_valid_o, n_out_ic_o, n_out_pbr_o, n_out_ill_o;
    logic [1:0] n_out_tp_o;
    logic [5:0] n_out_op_o;
    logic [4:0] n_out_rd_o, n_out_rs1_o, n_out_rs2_o;
    logic [31:0] n_out_imm_o, n_out_pc_o;
    logic [2:0] n_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_buf #(.DEPTH(4), .C_EN(1)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_ic_i(if_ic_i), .if_ins_i(if_ins_i),
        .if_pc_i(if_pc_i), .if_pbr_i(if_pbr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ic_o(out_ic_o), .out_tp_o(out_tp_o),
        .out_op_o(out_op_o), .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
        .out_imm_o(out_imm_o), .out_pc_o(out_pc_o), .out_pbr_o(out_pbr_o), .out_ill_o(out_ill_o),
        .cnt_o(cnt_o)
    );

    decode_buf #(.DEPTH(4), .C_EN(0)) dut_nc (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .if_valid_i(if_valid_i), .if_ready_o(n_if_ready_o), .if_ic_i(if_ic_i), .if_ins_i(if_ins_i),
        .if_pc_i(if_pc_i), .if_pbr_i(if_pbr_i),
        .out_valid_o(n_out_valid_o), .out_ready_i(out_ready_i), .out_ic_o(n_out_ic_o), .out_tp_o(n_out_tp_o),
        .out_op_o(n_out_op_o), .out_rd_o(n_out_rd_o), .out_rs1_o(n_out_rs1_o), .out_rs2_o(n_out_rs2_o),
        .out_imm_o(n_out_imm_o), .out_pc_o(n_out_pc_o), .out_pbr_o(n_out_pbr_o), .out_ill_o(n_out_ill_o),
        .cnt_o(n_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic ic, input logic [31:0] pc, input logic pbr);
        if_valid_i = 1'b1; if_ins_i = ins; if_ic_i = ic; if_pc_i = pc; if_pbr_i = pbr;
        step();
        if_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; clr = 1'b0; if_valid_i = 1'b0; out_ready_i = 1'b0;
        if_ins_i = '0; if_ic_i = 1'b0; if_pc_i = '0; if_pbr_i = 1'b0;
        step(); step();
        rst = 1'b1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0d exp=0", out_valid_o); end
        checks++; if (cnt_o !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt_o); end
        checks++; if (if_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0d exp=1", if_ready_o); end
        checks++; if ({out_op_o, out_tp_o, out_imm_o, out_pc_o} !== '0) begin failures++; $display("FAIL rst_fields got op=%0d tp=%0d imm=%h pc=%h exp=0", out_op_o, out_tp_o, out_imm_o, out_pc_o); end
    endtask

    task automatic test_i_decode();
        push_one(32'h0050_0093, 1'b0, 32'h100, 1'b0);
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0d exp=1", out_valid_o); end
        checks++; if (out_op_o !== OP_ADDI) begin failures++; $display("FAIL addi_op got=%0d exp=%0d", out_op_o, OP_ADDI); end
        checks++; if (out_tp_o !== 2'd3) begin failures++; $display("FAIL addi_tp got=%0d exp=3", out_tp_o); end
        checks++; if ({out_rd_o, out_rs1_o, out_rs2_o} !== {5'd1, 5'd0, 5'd0}) begin failures++; $display("FAIL addi_regs got=%0d/%0d/%0d exp=1/0/0", out_rd_o, out_rs1_o, out_rs2_o); end
        checks++; if (out_imm_o !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", out_imm_o); end
        checks++; if ({out_pc_o, out_ic_o, out_ill_o} !== {32'h100, 1'b0, 1'b0}) begin failures++; $display("FAIL addi_pc got=%h ic=%0d ill=%0d exp=100/0/0", out_pc_o, out_ic_o, out_ill_o); end
        pop_one();
    endtask

    task automatic test_r_decode();
        push_one(32'h4020_8133, 1'b0, 32'h110, 1'b0);
        push_one(32'h0020_8133, 1'b0, 32'h114, 1'b0);
        checks++; if (out_op_o !== OP_SUB) begin failures++; $display("FAIL sub_op got=%0d exp=%0d", out_op_o, OP_SUB); end
        checks++; if ({out_rd_o, out_rs1_o, out_rs2_o} !== {5'd2, 5'd1, 5'd2}) begin failures++; $display("FAIL sub_regs got=%0d/%0d/%0d exp=2/1/2", out_rd_o, out_rs1_o, out_rs2_o); end
        pop_one();
        checks++; if (out_op_o !== OP_ADD) begin failures++; $display("FAIL add_op got=%0d exp=%0d", out_op_o, OP_ADD); end
        checks++; if (out_pc_o !== 32'h114) begin failures++; $display("FAIL add_pc got=%h exp=114", out_pc_o); end
        pop_one();
    endtask

    task automatic test_c_decode();
        push_one(32'h0000_4505, 1'b1, 32'h500, 1'b1);
        checks++; if ({out_op_o, out_rd_o, out_rs1_o} !== {OP_ADDI, 5'd10, 5'd0}) begin failures++; $display("FAIL cli_op got op=%0d rd=%0d rs1=%0d exp=%0d/10/0", out_op_o, out_rd_o, out_rs1_o, OP_ADDI); end
        checks++; if ({out_imm_o, out_ic_o, out_ill_o, out_pbr_o} !== {32'd1, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL cli_imm got imm=%h ic=%0d ill=%0d pbr=%0d exp=1/1/0/1", out_imm_o, out_ic_o, out_ill_o, out_pbr_o); end
        checks++; if ({n_out_ill_o, n_out_op_o, n_out_tp_o, n_out_ic_o} !== {1'b1, 6'd0, 2'd3, 1'b1}) begin failures++; $display("FAIL noc_ill got ill=%0d op=%0d tp=%0d ic=%0d exp=1/0/3/1", n_out_ill_o, n_out_op_o, n_out_tp_o, n_out_ic_o); end
        checks++; if ({n_out_rd_o, n_out_imm_o, n_out_pc_o} !== {5'd0, 32'd0, 32'h500}) begin failures++; $display("FAIL noc_fields got rd=%0d imm=%h pc=%h exp=0/0/500", n_out_rd_o, n_out_imm_o, n_out_pc_o); end
        pop_one();
        push_one(32'h0000_BFFD, 1'b1, 32'h502, 1'b0);
        checks++; if ({out_op_o, out_tp_o, out_rd_o} !== {OP_JAL, 2'd3, 5'd0}) begin failures++; $display("FAIL cj_op got op=%0d tp=%0d rd=%0d exp=%0d/3/0", out_op_o, out_tp_o, out_rd_o, OP_JAL); end
        checks++; if (out_imm_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL cj_imm got=%h exp=fffffffe", out_imm_o); end
        pop_one();
        push_one(32'h0000_852E, 1'b1, 32'h504, 1'b0);
        checks++; if ({out_op_o, out_rd_o, out_rs1_o, out_rs2_o} !== {OP_ADD, 5'd10, 5'd0, 5'd11}) begin failures++; $display("FAIL cmv got op=%0d rd=%0d rs1=%0d rs2=%0d exp=%0d/10/0/11", out_op_o, out_rd_o, out_rs1_o, out_rs2_o, OP_ADD); end
        pop_one();
    endtask

    task automatic test_full();
        int acc = 0;
        out_ready_i = 1'b0;
        if_valid_i = 1'b1; if_ic_i = 1'b0; if_pbr_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if_ins_i = 32'h0000_0093 | (32'(k) << 20);
            if_pc_i  = 32'h200 + 32'(4 * k);
            if (if_ready_o) acc++;
            step();
        end
        checks++; if (acc !== 4) begin failures++; $display("FAIL full_accepted got=%0d exp=4", acc); end
        checks++; if ({if_ready_o, cnt_o} !== {1'b0, 3'd4}) begin failures++; $display("FAIL full_state got ready=%0d cnt=%0d exp=0/4", if_ready_o, cnt_o); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++; if ({if_ready_o, cnt_o} !== {1'b1, 3'd3}) begin failures++; $display("FAIL full_reopen got ready=%0d cnt=%0d exp=1/3", if_ready_o, cnt_o); end
        step();
        if_valid_i = 1'b0;
        checks++; if (cnt_o !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", cnt_o); end
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (out_pc_o !== 32'h204 + 32'(4 * j)) begin failures++; $display("FAIL fifo_order[%0d] got=%h exp=%h", j, out_pc_o, 32'h204 + 32'(4 * j)); end
            step();
        end
        out_ready_i = 1'b0;
        checks++; if ({out_valid_o, cnt_o} !== {1'b0, 3'd0}) begin failures++; $display("FAIL drain got valid=%0d cnt=%0d exp=0/0", out_valid_o, cnt_o); end
    endtask

    task automatic test_clr();
        for (int k = 0; k < 3; k++) push_one(32'h0050_0093, 1'b0, 32'h600 + 32'(4 * k), 1'b0);
        checks++; if (cnt_o !== 3'd3) begin failures++; $display("FAIL clr_pre got=%0d exp=3", cnt_o); end
        clr = 1'b1; if_valid_i = 1'b1; if_pc_i = 32'h60C;
        step();
        clr = 1'b0; if_valid_i = 1'b0;
        checks++; if ({out_valid_o, cnt_o, out_pc_o} !== {1'b0, 3'd0, 32'h0}) begin failures++; $display("FAIL clr_empty got valid=%0d cnt=%0d pc=%h exp=0/0/0", out_valid_o, cnt_o, out_pc_o); end
        step();
        checks++; if (cnt_o !== 3'd0) begin failures++; $display("FAIL clr_nowrite got=%0d exp=0", cnt_o); end
    endtask

    task automatic test_back_to_back();
        push_one(32'h0050_0093, 1'b0, 32'h400, 1'b0);
        if_valid_i = 1'b1; out_ready_i = 1'b1;
        for (int k = 1; k < 3; k++) begin
            if_pc_i = 32'h400 + 32'(4 * k);
            step();
            checks++; if ({cnt_o, out_pc_o} !== {3'd1, 32'h400 + 32'(4 * k)}) begin failures++; $display("FAIL b2b[%0d] got cnt=%0d pc=%h exp=1/%h", k, cnt_o, out_pc_o, 32'h400 + 32'(4 * k)); end
        end
        if_valid_i = 1'b0;
        step();
        out_ready_i = 1'b0;
        checks++; if (cnt_o !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", cnt_o); end
    endtask

    task automatic test_en_hold_and_reset();
        push_one(32'h0050_0093, 1'b0, 32'h300, 1'b0);
        push_one(32'h0050_0093, 1'b0, 32'h304, 1'b0);
        en = 1'b0; if_valid_i = 1'b1; if_pc_i = 32'h308; out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({cnt_o, out_pc_o, if_ready_o} !== {3'd2, 32'h300, 1'b0}) begin failures++; $display("FAIL en_hold[%0d] got cnt=%0d pc=%h ready=%0d exp=2/300/0", k, cnt_o, out_pc_o, if_ready_o); end
        end
        en = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; if_valid_i = 1'b0; out_ready_i = 1'b0;
        checks++; if ({out_valid_o, cnt_o, if_ready_o} !== {1'b0, 3'd0, 1'b1}) begin failures++; $display("FAIL midrst_state got valid=%0d cnt=%0d ready=%0d exp=0/0/1", out_valid_o, cnt_o, if_ready_o); end
        checks++; if ({out_op_o, out_tp_o, out_rd_o, out_imm_o, out_pc_o, out_ill_o} !== '0) begin failures++; $display("FAIL midrst_fields got op=%0d tp=%0d rd=%0d imm=%h pc=%h exp=0", out_op_o, out_tp_o, out_rd_o, out_imm_o, out_pc_o); end
    endtask

    initial begin
        test_reset();
        test_i_decode();
        test_r_decode();
        test_c_decode();
        test_full();
        test_clr();
        test_back_to_back();
        test_en_hold_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_buf.md
DECODE_BUF -- requirements
Module: decode_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning decoded-entry queue depth (power of two, >=2).
REQ-002 SHALL have parameter C_EN, default 1, meaning RV32C decode enabled (0: every compressed input is flagged illegal).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, global enable (rdy); low freezes all state.
REQ-006 SHALL have port clr, input, 1, pipeline flush from ROB on mispredict.
REQ-007 SHALL have ports if_valid_i (in, 1), if_ready_o (out, 1), if_ic_i (in, 1, 0=I 1=C), if_ins_i (in, DAT_W), if_pc_i (in, RAM_ADR_W) and if_pbr_i (in, 1, predicted taken), forming the fetch-side handshake.
REQ-008 SHALL have ports out_valid_o (out, 1), out_ready_i (in, 1), out_ic_o, out_tp_o (2), out_op_o (OP_W), out_rd_o, out_rs1_o and out_rs2_o (REG_BIT each), out_imm_o (DAT_W), out_pc_o (RAM_ADR_W), out_pbr_o (1) and out_ill_o (1), forming the shared issue record to RF and ROB.
REQ-009 SHALL have port cnt_o, output, clog2(DEPTH)+1, current occupancy.

Function
REQ-010 SHALL push a decoded record when en && !clr && if_valid_i && if_ready_o, and pop the head when en && !clr && out_valid_o && out_ready_i.
REQ-011 SHALL drive if_ready_o = en && (cnt < DEPTH); when full, a same-cycle pop SHALL NOT re-open ready (no bypass).
REQ-012 SHALL drive out_valid_o = (cnt != 0); an entry accepted in cycle N is visible at the head in cycle N+1 (latency 1).
REQ-013 SHALL drive all out_* data fields to 0 while empty, and from the head entry otherwise.
REQ-014 SHALL wrap read/write pointers modulo DEPTH; simultaneous push and pop SHALL leave cnt unchanged.
REQ-015 SHALL, on clr, empty the queue next cycle (cnt=0, pointers 0) and drop any same-cycle push; clr SHALL override en.
REQ-016 SHALL, with en low, hold pointers, count and entries, with if_ready_o=0.
REQ-017 SHALL encode tp as 0 branch/JALR, 1 load, 2 store, 3 ALU/LUI/AUIPC/JAL, and op using the shared op codes.
REQ-018 SHALL decode RV32I rd/rs1/rs2/imm per format, zeroing unused register fields; SUB/SRA/SRAI SHALL be selected by ins[30]=1.
REQ-019 SHALL decode RV32C by quadrant and funct3: c.beqz/c.bnez from funct3 110/111; c.srli/c.srai/c.andi/ALU ops from ins[11:10]; c.sub/xor/or/and from ins[6:5]; c.mv uses rs1=0.
REQ-020 SHALL compute C.J/C.JAL imm sign-extended from the compressed encoding, not 0.
REQ-021 SHALL set out_ill_o=1, op=0, tp=3, rd=rs1=rs2=0 and imm=0 for unknown opcodes/funct3, or for if_ic_i=1 with C_EN=0; illegal entries SHALL still be queued in order.
REQ-022 SHALL pass pc, pbr and ic through unchanged with each entry.

Reset
REQ-023 SHALL, on rst=0 at a clock edge, clear pointers and cnt, so out_valid_o=0, all out_* fields=0, cnt_o=0, and if_ready_o=en.
REQ-024 SHALL abandon any in-flight push/pop when reset asserts mid-operation; reset SHALL override clr and en.

Structure
REQ-025 SHALL take OP_W, op codes, DAT_W, RAM_ADR_W, REG_BIT and the tp encodings from the shared header package; no local redefinition.
REQ-026 SHALL keep decode as one combinational sub-module rv_dec_core (ins, ic -> tp, op, rd, rs1, rs2, imm, ill), with decode_buf holding only the queue and handshake.

Verification
REQ-027 SHALL verify: ins 0x00500093 I, pc 0x100 pushed at N -> at N+1 valid, op=ADDI, tp=3, rd=1, rs1=0, imm=5, pc=0x100.
REQ-028 SHALL verify: 0x40208133 -> op=SUB, rd=2, rs1=1, rs2=2; 0x00208133 -> op=ADD.
REQ-029 SHALL verify: C 0x4505 -> op=ADDI, rd=10, rs1=0, imm=1, ic=1; same input with C_EN=0 -> ill=1, op=0.
REQ-030 SHALL verify: DEPTH=4, out_ready_i=0, 5 valid inputs -> 4 accepted, if_ready_o=0 and cnt_o=4; one pop -> ready returns the following cycle and FIFO order is preserved.
REQ-031 SHALL verify: cnt=3 with clr and if_valid_i both high -> next cycle cnt=0, out_valid_o=0, no entry written.
REQ-032 SHALL verify: en=0 for 3 cycles with valid/ready high -> cnt and head unchanged; rst=0 mid-stream -> all outputs zero next cycle.
